bram_port_arbiter: RTL

- Shares one read/write port of a dual-port block RAM (bram_2rw port A or B) between NUM_REQ requesters.
- Round-robin arbitration; one access per cycle; registered 1-cycle BRAM read latency.
- Read data returns on a single response channel tagged with requester ID, through a credit-guarded response FIFO so rsp_ready backpressure never drops data.

---
 rtl/bram_ctrl_pkg.sv | 35 +++
 rtl/bram_arb_rsp_fifo.sv | 83 ++++++++
 rtl/bram_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_ctrl_pkg
// Description : Shared constants and helpers for the BRAM port arbiter slice.
//               clog2 for parameter-derived widths, default response FIFO
//               depth, and the response entry width {id, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_ctrl_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Depth 3 covers the two-cycle credit loop (inflight + one queued entry)
    // plus the entry being popped, so reads can issue every cycle.
    localparam int c_default_rsp_depth  = 3;
    localparam int c_default_id_width   = 1;
    localparam int c_default_data_width = 32;

    // Response entry carries {id, data}.
    localparam int c_rsp_entry_width = c_default_id_width + c_default_data_width;

    function automatic int rsp_entry_width(input int id_w, input int data_w);
        return id_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arb_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_rsp_fifo
// Description : Small synchronous FIFO buffering tagged read responses.
//               Head entry is presented combinationally; output data is
//               forced to zero while empty.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_push/i_push_data - write side
//               i_pop              - consume head (ignored while empty)
//               o_valid/o_data     - head entry
//               o_count            - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arb_rsp_fifo
    import bram_ctrl_pkg::*;
#(
    parameter int DEPTH = c_default_rsp_depth,
    parameter int WIDTH = c_rsp_entry_width
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_data,
    output logic [clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_ptr_w = clog2(DEPTH);
    localparam int c_cnt_w = clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_do_pop = i_pop & o_valid;
    assign o_valid  = (r_count != '0);
    assign o_data   = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count  = r_count;

    // Storage needs no reset: contents are only visible while count > 0.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The upstream credit check guarantees a free slot for every push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && (r_count == c_cnt_w'(DEPTH))));
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin sharing of one BRAM read/write port between
//               NUM_REQ requesters. Reads return {id, data} through a
//               credit-guarded response FIFO, so rsp_ready backpressure
//               never loses data.
// Ports       : clk, rst                     - clock, sync active-high reset
//               req_valid/ready/we/addr/wdata - packed per-requester requests
//               rsp_valid/ready/id/data       - tagged read responses
//               bram_en/we/addr/din, bram_dout - BRAM port (1-cycle read)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int RSP_DEPTH  = c_default_rsp_depth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_din,
    input  logic [DATA_WIDTH-1:0]         bram_dout
);

    localparam int c_entry_w = rsp_entry_width(ID_WIDTH, DATA_WIDTH);
    localparam int c_cnt_w   = clog2(RSP_DEPTH + 1);
    localparam int c_occ_w   = c_cnt_w + 1;

    logic [ID_WIDTH-1:0]  r_ptr;
    logic                 r_inflight;
    logic [ID_WIDTH-1:0]  r_inflight_id;

    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_WIDTH-1:0]  w_gidx;
    logic                 w_rd_grant;
    logic                 w_credit;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic [c_occ_w-1:0]   w_occupancy;
    logic [c_entry_w-1:0] w_head;
    logic                 w_pop;

    // Credit counts buffered plus in-flight reads; it deliberately ignores
    // rsp_ready so a slot freed this cycle is only reused next cycle.
    assign w_occupancy = c_occ_w'(w_fifo_count) + c_occ_w'(r_inflight);
    assign w_credit    = (w_occupancy < c_occ_w'(RSP_DEPTH));
    assign w_elig      = req_valid & (req_we | {NUM_REQ{w_credit}});

    // Rotating priority: position k of the scan is requester (ptr + k) mod N.
    always_comb begin
        int  pos;
        logic found;
        pos     = 0;
        found   = 1'b0;
        w_grant = '0;
        w_gidx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(r_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && !rst && (pos == i) && w_elig[i]) begin
                    w_grant[i] = 1'b1;
                    w_gidx     = ID_WIDTH'(i);
                    found      = 1'b1;
                end
            end
        end
    end

    assign req_ready  = w_grant;
    assign w_rd_grant = |(w_grant & ~req_we);

    always_comb begin
        bram_en   = |w_grant;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                bram_we   = req_we[i];
                bram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bram_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            r_inflight    <= 1'b0;
            r_inflight_id <= '0;
        end else begin
            r_inflight <= w_rd_grant;
            if (|w_grant) begin
                r_inflight_id <= w_gidx;
                r_ptr         <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + ID_WIDTH'(1);
            end
        end
    end

    // bram_dout is valid the cycle after the read enable, aligned with
    // r_inflight, so it is captured straight into the FIFO.
    bram_arb_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (c_entry_w)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_id, bram_dout}),
        .i_pop       (w_pop),
        .o_valid     (rsp_valid),
        .o_data      (w_head),
        .o_count     (w_fifo_count)
    );

    assign w_pop              = rsp_valid & rsp_ready;
    assign {rsp_id, rsp_data} = w_head;

endmodule
`default_nettype wire
